// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: scan control, mux select/sample and frame handshake bundle.
// master is the sequencer side, slave is the controller/mux/consumer side.
interface mux_scan_sequencer_if #(parameter int DWELL_W = 8);
    logic               start;
    logic               continuous;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic               frame_ready;
    logic               overrun_clr;
    logic [1:0]         select;
    logic [3:0]         frame;
    logic               frame_valid;
    logic               busy;
    logic               overrun;

    modport master (
        input  start, continuous, chan_mask, dwell, mux_out, frame_ready, overrun_clr,
        output select, frame, frame_valid, busy, overrun
    );

    modport slave (
        output start, continuous, chan_mask, dwell, mux_out, frame_ready, overrun_clr,
        input  select, frame, frame_valid, busy, overrun
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select over enabled channels, waits dwell cycles,
// samples each channel and hands the assembled 4-bit frame out over valid/ready.
module mux_scan_sequencer #(parameter int DWELL_W = 8) (
    input logic                  clk,
    input logic                  rst,
    mux_scan_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t             state;
    logic [3:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [3:0]         acc;
    logic [3:0]         above;
    logic               launch;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // a scan starts from IDLE on start, or chains from DONE when continuous
    always_comb begin
        above  = mask_q & (4'b1110 << bus.select);
        launch = (bus.chan_mask != 4'd0) &&
                 (state == IDLE ? bus.start : (state == DONE) && bus.continuous);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            mask_q          <= '0;
            dwell_q         <= '0;
            cnt             <= '0;
            acc             <= '0;
            bus.select      <= '0;
            bus.frame       <= '0;
            bus.frame_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            if (bus.overrun_clr)
                bus.overrun <= 1'b0;
            if (bus.frame_valid && bus.frame_ready)
                bus.frame_valid <= 1'b0;
            // a frame loaded on the accepting edge replaces the consumed one
            if (state == DONE) begin
                bus.frame       <= acc & mask_q;
                bus.frame_valid <= 1'b1;
                if (bus.frame_valid && !bus.frame_ready)
                    bus.overrun <= 1'b1;
            end
            if (launch) begin
                mask_q     <= bus.chan_mask;
                dwell_q    <= bus.dwell;
                cnt        <= bus.dwell;
                acc        <= '0;
                bus.select <= lowest(bus.chan_mask);
                bus.busy   <= 1'b1;
                state      <= SETTLE;
            end else if (state == DONE) begin
                bus.busy <= 1'b0;
                state    <= IDLE;
            end else if (state == SETTLE) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    acc[bus.select] <= bus.mux_out;
                    if (above != 4'd0) begin
                        bus.select <= lowest(above);
                        cnt        <= dwell_q;
                    end else begin
                        state <= DONE;
                    end
                end
            end
        end
    end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Channel scanner that sits directly around the 4:1 top-level mux. It drives the mux's 2-bit select, waits a programmable settle time, and samples the 1-bit mux output. It assembles the four channel samples into a 4-bit frame and presents that frame with a valid/ready handshake. It supports masked channels, single-shot and continuous scanning, and a sticky overrun flag.

Parameters:
DWELL_W, 8, width of the dwell (settle) count input and the internal counter.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; one clock, reset is asynchronous and active-high
start  input  1  single-cycle request to begin a scan; ignored while busy=1
continuous  input  1  1 = automatically restart after each frame; read live at the DONE state
chan_mask  input  4  bit i = 1 enables channel i; latched at scan start
dwell  input  DWELL_W  extra settle cycles per channel; latched at scan start
mux_out  input  1  output of the 4:1 mux for the current select
frame_ready  input  1  consumer accepts the frame when high together with frame_valid
overrun_clr  input  1  clears the sticky overrun flag
select  output  2  mux select; index of the channel being scanned
frame  output  4  bit i = sample of channel i; masked channels read 0
frame_valid  output  1  frame holds an unaccepted result
busy  output  1  high while a scan is in progress
overrun  output  1  sticky; a new frame replaced an unaccepted frame

Behaviour:
- Reset (async, immediate): select=0, frame=0, frame_valid=0, busy=0, overrun=0. Internal accumulator and counter are 0; state is IDLE.
- States: IDLE, SETTLE, DONE.
- IDLE: busy=0.
  - On start=1 with chan_mask!=0: latch mask and dwell, set select to the lowest enabled index, counter=dwell, clear the accumulator, set busy=1, go to SETTLE. All of this happens on the same edge.
  - On start=1 with chan_mask==0: no action; stay in IDLE; no frame is produced.
- SETTLE, counter!=0: decrement the counter.
- SETTLE, counter==0:
  - Sample mux_out into accumulator bit [select].
  - If a higher enabled index exists: select is set to the next enabled index, counter reloads to the latched dwell, and the state stays SETTLE.
  - Otherwise go to DONE.
- SETTLE timing: each channel's sample occurs dwell+1 edges after select changes. Masked channels are never selected.
- DONE (1 cycle):
  - frame <= accumulator, with masked bits forced to 0.
  - frame_valid <= 1.
  - If frame_valid was 1 and not accepted on this edge, overrun <= 1.
  - If continuous=1: re-enter scan as from start, re-latching mask and dwell. If the new mask is 0, go to IDLE.
  - Otherwise go to IDLE; busy=0 from this edge.
- Frame latency: N enabled channels × (dwell+1) edges + 1, counted from the start edge to frame_valid=1.
- Handshake:
  - frame_valid & frame_ready on an edge clears frame_valid, unless DONE loads a new frame on the same edge.
  - In that case the new frame wins, frame_valid stays 1, and no overrun is raised, because the old frame was accepted.
  - frame is stable while frame_valid=1 and no DONE occurs.
- Overrun: overrun_clr clears it. If set and clear occur on the same edge, set wins.
- start while busy=1: ignored; no effect on the current scan.
- Clearing continuous mid-scan: the current frame completes, then the block returns to IDLE.
- Counter arithmetic: unsigned DWELL_W bits. dwell=2^DWELL_W−1 is legal. The counter never wraps below 0.

Test Plan:
1. Full scan: mask=1111, dwell=0, mux inputs ch0..3=0,1,0,1, one start pulse.
   -> select=0,1,2,3 on edges 0..3; frame=4'b1010; frame_valid=1 after edge 5; busy=0 after edge 5.
2. Masked scan: mask=0101, dwell=3, all inputs=1.
   -> select visits only 0 then 2, each held 4 cycles; select never equals 1 or 3; frame=4'b0101; frame_valid after edge 9.
3. Overrun: continuous=1, mask=1111, dwell=0, frame_ready=0.
   -> second DONE sets overrun=1, and frame shows the new data.
   -> pulse overrun_clr -> overrun=0.
   -> overrun_clr on the same edge as a set -> overrun stays 1.
4. Empty mask: mask=0000, start.
   -> busy, frame_valid and select stay 0 for 20 cycles.
5. Accept on DONE edge: frame_ready=1 held while a second frame completes.
   -> frame_valid stays 1, frame updates, overrun=0.
   -> start pulses mid-scan are ignored, and the frame timing is unchanged.
6. Reset mid-scan: assert rst during SETTLE with dwell=5.
   -> all outputs are 0 before the next edge.
   -> after release, a new start gives the normal latency from scenario 1.
